// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
//   Shared definitions for the traffic-light controller slice:
//     - interval codes issued by the sequencing FSM to the interval timer
//     - parameter-select codes used on the Prog_Sync programming path
//     - default durations (seconds) and the parameter-set struct
//     - lamp encodings used by the sequencing FSM
//     - timer state encoding
//     - helpers: zero-to-one clamp and interval-code decode
// ---------------------------------------------------------------------------
package tlc_pkg;

    // Interval codes from the sequencing FSM. Codes 4..7 are reserved and
    // decode to the one-second safe minimum.
    localparam logic [2:0] INT_BASE  = 3'd0;
    localparam logic [2:0] INT_EXT   = 3'd1;
    localparam logic [2:0] INT_YEL   = 3'd2;
    localparam logic [2:0] INT_BASE2 = 3'd3;

    // Parameter select codes on the programming path.
    typedef enum logic [1:0] {
        SEL_BASE     = 2'd0,
        SEL_EXT      = 2'd1,
        SEL_YEL      = 2'd2,
        SEL_DEFAULTS = 2'd3
    } param_sel_t;

    // Default durations in seconds.
    localparam logic [3:0] T_BASE_DEF = 4'd6;
    localparam logic [3:0] T_EXT_DEF  = 4'd3;
    localparam logic [3:0] T_YEL_DEF  = 4'd2;

    // The three programmable durations, held together.
    typedef struct packed {
        logic [3:0] t_base;
        logic [3:0] t_ext;
        logic [3:0] t_yel;
    } time_params_t;

    localparam time_params_t PARAMS_DEF = '{
        t_base: T_BASE_DEF,
        t_ext:  T_EXT_DEF,
        t_yel:  T_YEL_DEF
    };

    // Lamp encodings driven by the sequencing FSM (one-hot R/Y/G).
    typedef enum logic [2:0] {
        LAMP_OFF    = 3'b000,
        LAMP_GREEN  = 3'b001,
        LAMP_YELLOW = 3'b010,
        LAMP_RED    = 3'b100
    } lamp_t;

    // Interval timer states.
    typedef enum logic {
        TMR_IDLE  = 1'b0,
        TMR_COUNT = 1'b1
    } timer_state_t;

    // A zero duration would never expire cleanly; store it as one second.
    function automatic logic [3:0] clamp_time(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

    // Map an interval code to a duration in seconds (5-bit result so that
    // the doubled base of up to 2 x 15 = 30 fits without overflow).
    function automatic logic [4:0] decode_interval(input logic [2:0]   code,
                                                   input time_params_t p);
        logic [4:0] secs;
        case (code)
            INT_BASE:  secs = {1'b0, p.t_base};
            INT_EXT:   secs = {1'b0, p.t_ext};
            INT_YEL:   secs = {1'b0, p.t_yel};
            INT_BASE2: secs = {p.t_base, 1'b0};
            default:   secs = 5'd1;
        endcase
        return secs;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
//   Modulo-TICK_DIV cycle counter producing a one-cycle tick on the last
//   cycle of each period. A synchronous clear restarts the phase so that
//   the next tick falls a full TICK_DIV cycles after the clearing edge.
//
//   Ports:
//     clk    in  1  system clock
//     reset  in  1  synchronous, active-high reset (count -> 0)
//     clear  in  1  synchronous phase restart (count -> 0)
//     tick   out 1  high while the count sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    // Keep at least one counter bit so TICK_DIV = 1 still elaborates
    // (the count then stays at 0 and tick is constantly high).
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Decoded from the counter register only; the consumer samples it on
    // the edge that closes the period.
    assign tick = (count == LAST);

endmodule

// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
//   Countdown timer and duration store for the traffic-light sequencing FSM.
//   Latches the FSM's interval code on start_timer, counts whole seconds
//   from a phase-aligned divider, and pulses expired for one cycle when the
//   count completes. Holds the programmable base/extension/yellow durations,
//   rewritten through the synchronized Prog_Sync path. A second,
//   free-running divider produces the one_hz blink tick.
//
//   Parameters:
//     TICK_DIV        clock cycles per one-second tick
//
//   Ports:
//     clk             in  1  system clock
//     Reset           in  1  synchronous, active-high reset
//     Prog_Sync       in  1  one-cycle synchronized program strobe
//     Time_Param_Sel  in  2  0 = base, 1 = ext, 2 = yellow, 3 = defaults
//     Time_Value      in  4  new duration in seconds (0 stored as 1)
//     interval        in  3  duration code, sampled on start_timer
//     start_timer     in  1  start / restart the countdown
//     expired         out 1  one-cycle pulse on countdown completion
//     busy            out 1  countdown active
//     Time_Left       out 5  seconds remaining, 0 when idle
//     one_hz          out 1  free-running one-cycle tick pulse
// ---------------------------------------------------------------------------
module interval_timer
    import tlc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Prog_Sync,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    input  logic [2:0] interval,
    input  logic       start_timer,
    output logic       expired,
    output logic       busy,
    output logic [4:0] Time_Left,
    output logic       one_hz
);

    // -----------------------------------------------------------------------
    // Duration store
    // -----------------------------------------------------------------------
    time_params_t params;

    always_ff @(posedge clk) begin
        if (Reset) begin
            params <= PARAMS_DEF;
        end else if (Prog_Sync) begin
            case (param_sel_t'(Time_Param_Sel))
                SEL_BASE:     params.t_base <= clamp_time(Time_Value);
                SEL_EXT:      params.t_ext  <= clamp_time(Time_Value);
                SEL_YEL:      params.t_yel  <= clamp_time(Time_Value);
                SEL_DEFAULTS: params        <= PARAMS_DEF;
            endcase
        end
    end

    // Decoded from the registered parameters, so a write in the same cycle
    // as start_timer is not yet visible and the old value is used. A write
    // during a count only affects later starts because Time_Left already
    // holds the loaded value.
    logic [4:0] load_secs;
    assign load_secs = decode_interval(interval, params);

    // -----------------------------------------------------------------------
    // Second dividers
    // -----------------------------------------------------------------------
    logic count_tick;
    logic free_tick;

    // Countdown phase restarts on every start so the first decrement lands
    // exactly TICK_DIV cycles after the start edge.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_count_div (
        .clk   (clk),
        .reset (Reset),
        .clear (start_timer),
        .tick  (count_tick)
    );

    // Blink tick is independent of the countdown phase.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_free_div (
        .clk   (clk),
        .reset (Reset),
        .clear (1'b0),
        .tick  (free_tick)
    );

    // -----------------------------------------------------------------------
    // Countdown FSM
    // -----------------------------------------------------------------------
    timer_state_t state, state_next;
    logic [4:0]   time_left_next;
    logic         expired_next;
    logic         busy_next;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        time_left_next = Time_Left;
        expired_next   = 1'b0;

        if (start_timer) begin
            // Start or restart wins over any tick in the same cycle, so an
            // aborted count never reports expiry.
            state_next     = TMR_COUNT;
            time_left_next = load_secs;
        end else begin
            case (state)
                TMR_IDLE: begin
                    time_left_next = 5'd0;
                end
                TMR_COUNT: begin
                    if (count_tick) begin
                        if (Time_Left <= 5'd1) begin
                            state_next     = TMR_IDLE;
                            time_left_next = 5'd0;
                            expired_next   = 1'b1;
                        end else begin
                            time_left_next = Time_Left - 5'd1;
                        end
                    end
                end
                default: begin
                    state_next     = TMR_IDLE;
                    time_left_next = 5'd0;
                end
            endcase
        end

        busy_next = (state_next == TMR_COUNT);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= TMR_IDLE;
            Time_Left <= 5'd0;
            expired   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            Time_Left <= time_left_next;
            expired   <= expired_next;
            busy      <= busy_next;
        end
    end

    // Registered so one_hz has no combinational path from the divider.
    always_ff @(posedge clk) begin
        if (Reset) begin
            one_hz <= 1'b0;
        end else begin
            one_hz <= free_tick;
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_interval_timer
//   Directed scenarios plus randomized traffic for interval_timer with
//   TICK_DIV = 4. A reference model tracks edge counts and derives expected
//   outputs arithmetically from the start edge, the decoded duration and
//   the last reset edge; every cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_interval_timer;

    localparam int D = 4;

    logic       clk            = 1'b0;
    logic       Reset          = 1'b1;
    logic       Prog_Sync      = 1'b0;
    logic [1:0] Time_Param_Sel = 2'd0;
    logic [3:0] Time_Value     = 4'd0;
    logic [2:0] interval       = 3'd0;
    logic       start_timer    = 1'b0;
    logic       expired;
    logic       busy;
    logic [4:0] Time_Left;
    logic       one_hz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interval_timer #(
        .TICK_DIV (D)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .Prog_Sync      (Prog_Sync),
        .Time_Param_Sel (Time_Param_Sel),
        .Time_Value     (Time_Value),
        .interval       (interval),
        .start_timer    (start_timer),
        .expired        (expired),
        .busy           (busy),
        .Time_Left      (Time_Left),
        .one_hz         (one_hz)
    );

    // ---------------- reference model ----------------
    int e        = 0;   // posedge count
    int r        = 0;   // edge of the most recent reset
    int m_s      = 0;   // edge at which the current count started
    int m_n      = 0;   // seconds loaded for the current count
    bit m_active = 1'b0;
    int m_base   = 6;
    int m_ext    = 3;
    int m_yel    = 2;

    function automatic int decode(input int code);
        case (code)
            0:       return m_base;
            1:       return m_ext;
            2:       return m_yel;
            3:       return 2 * m_base;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs the DUT samples on this
    // edge, then compare all outputs half a cycle later.
    task automatic step();
        int el;
        int exp_busy;
        int exp_tl;
        int exp_expired;
        int exp_hz;
        int v;
        @(posedge clk);
        e++;
        if (Reset) begin
            r        = e;
            m_active = 1'b0;
            m_base   = 6;
            m_ext    = 3;
            m_yel    = 2;
        end else begin
            if (start_timer) begin
                m_s      = e;
                m_n      = decode(int'(interval));
                m_active = 1'b1;
            end
            if (Prog_Sync) begin
                v = (Time_Value == 4'd0) ? 1 : int'(Time_Value);
                case (Time_Param_Sel)
                    2'd0: m_base = v;
                    2'd1: m_ext  = v;
                    2'd2: m_yel  = v;
                    default: begin
                        m_base = 6;
                        m_ext  = 3;
                        m_yel  = 2;
                    end
                endcase
            end
        end
        @(negedge clk);
        el          = e - m_s;
        exp_busy    = (m_active && el < m_n * D) ? 1 : 0;
        exp_tl      = exp_busy ? (m_n - el / D) : 0;
        exp_expired = (m_active && el == m_n * D) ? 1 : 0;
        exp_hz      = (e > r && ((e - r) % D) == 0) ? 1 : 0;
        check("busy",      32'(busy),      exp_busy);
        check("time_left", 32'(Time_Left), exp_tl);
        check("expired",   32'(expired),   exp_expired);
        check("one_hz",    32'(one_hz),    exp_hz);
    endtask

    task automatic pulse_start(input int code);
        interval    = 3'(code);
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
    endtask

    task automatic prog(input int sel, input int value);
        Time_Param_Sel = 2'(sel);
        Time_Value     = 4'(value);
        Prog_Sync      = 1'b1;
        step();
        Prog_Sync      = 1'b0;
    endtask

    // Counts edges from the start edge (m0 already elapsed) until expired is
    // seen; a missing pulse within the budget reports -1.
    task automatic wait_expired(input string tag, input int m0, input int exp_cycles);
        int m;
        bit seen;
        m    = m0;
        seen = 1'b0;
        while (!seen && m < 400) begin
            step();
            m++;
            if (expired === 1'b1) seen = 1'b1;
        end
        check(tag, seen ? 32'(m) : 32'hFFFF_FFFF, 32'(exp_cycles));
    endtask

    task automatic run(input string tag, input int code, input int secs);
        pulse_start(code);
        check({tag, "_load"}, 32'(Time_Left), 32'(secs));
        wait_expired({tag, "_cycles"}, 0, secs * D);
    endtask

    initial begin
        // Reset and idle state
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        check("reset_busy",      32'(busy),      0);
        check("reset_time_left", 32'(Time_Left), 0);
        check("reset_expired",   32'(expired),   0);

        // Default base count
        run("base_default", 0, 6);

        // Programmed extension, then zero stored as one
        prog(1, 9);
        run("ext_9", 1, 9);
        prog(1, 0);
        run("ext_zero", 1, 1);

        // Doubled base at the maximum, then a reserved code
        prog(0, 15);
        run("base2_30", 3, 30);
        run("code5", 5, 1);

        // Restart two cycles before the final tick of a base count
        prog(3, 0);
        pulse_start(0);
        repeat (21) step();
        pulse_start(2);
        wait_expired("restart_yel", 0, 8);

        // Write during a count leaves it unchanged
        pulse_start(0);
        repeat (5) step();
        prog(0, 4);
        wait_expired("prog_midcount", 6, 24);
        run("base_4", 0, 4);
        prog(3, 7);
        run("defaults_base", 0, 6);

        // Same-cycle program and start uses the old value
        Time_Param_Sel = 2'd0;
        Time_Value     = 4'd2;
        Prog_Sync      = 1'b1;
        interval       = 3'd0;
        start_timer    = 1'b1;
        step();
        Prog_Sync      = 1'b0;
        start_timer    = 1'b0;
        check("same_cycle_load", 32'(Time_Left), 6);
        wait_expired("same_cycle_cycles", 0, 24);
        run("after_same_cycle", 0, 2);

        // Reset in the middle of a count
        pulse_start(1);
        repeat (10) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_busy",      32'(busy),      0);
        check("midrst_time_left", 32'(Time_Left), 0);
        check("midrst_expired",   32'(expired),   0);
        run("rst_base", 0, 6);
        run("rst_ext",  1, 3);
        run("rst_yel",  2, 2);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 2000; i++) begin
            Reset          = ($urandom_range(0, 149) == 0);
            start_timer    = ($urandom_range(0, 11) == 0);
            interval       = 3'($urandom_range(0, 7));
            Prog_Sync      = ($urandom_range(0, 9) == 0);
            Time_Param_Sel = 2'($urandom_range(0, 3));
            Time_Value     = 4'($urandom_range(0, 15));
            step();
        end
        Reset       = 1'b0;
        start_timer = 1'b0;
        Prog_Sync   = 1'b0;
        repeat (130) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Timer and time-parameter store that serves the traffic-light sequencing FSM. It latches the FSM's `interval` code on `start_timer`, counts whole seconds from an internal divider, and returns a one-cycle `expired` pulse. It also holds the three programmable durations (base, extension, yellow), which are rewritten through the synchronized `Prog_Sync` path. It sits between the FSM and the board-level switch/button synchronizers.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick; the bench uses 4.
- `clk` in 1: system clock, the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `Prog_Sync` in 1: one-cycle, already-synchronized program strobe.
- `Time_Param_Sel` in 2: parameter to program. 0 = tBASE, 1 = tEXT, 2 = tYEL, 3 = restore all defaults.
- `Time_Value` in 4: new duration in seconds. 0 is stored as 1.
- `interval` in 3: duration code from the FSM, sampled only on `start_timer`.
- `start_timer` in 1: one-cycle request to start or restart the countdown.
- `expired` out 1: one-cycle pulse when the countdown completes.
- `busy` out 1: high while a countdown is active.
- `Time_Left` out 5: seconds remaining, for display; 0 when idle.
- `one_hz` out 1: one-cycle tick pulse, free-running, for walk-lamp blinking.

## Operation
- Parameter registers are 4 bits each. Reset and restore values: tBASE = 6, tEXT = 3, tYEL = 2.
- On `Prog_Sync`, the selected parameter is written with `max(Time_Value, 1)`.
  - Sel 3 reloads all three defaults and ignores `Time_Value`.
- A write never alters a countdown already in progress. The new value applies from the next `start_timer`.
- `interval` decode to N seconds, 5-bit arithmetic:
  - 0 → tBASE
  - 1 → tEXT
  - 2 → tYEL
  - 3 → 2×tBASE (maximum 30)
  - 4–7 → 1 (safe minimum)
- States:
  - IDLE: `busy` = 0, `Time_Left` = 0.
  - COUNT: `busy` = 1. `Time_Left` decrements on each internal second tick.
- IDLE → COUNT on `start_timer`.
  - Loads N into `Time_Left`.
  - Clears the second-divider phase so the first tick falls a full `TICK_DIV` cycles later.
- COUNT → IDLE when a tick arrives with `Time_Left` = 1. `expired` pulses, and `Time_Left` becomes 0.
- `start_timer` in COUNT restarts with the new interval.
  - The aborted count produces no `expired`.
  - If the restart coincides with the final tick, the restart wins and `expired` stays 0.
- `Prog_Sync` and `start_timer` in the same cycle: the decode uses the old parameter value.
- `one_hz` comes from a free-running divider that is independent of the countdown phase.
- Reset mid-count: back to IDLE, parameters to defaults, no `expired`.

## Timing
- Cycle numbering: `start_timer` is sampled at edge e0.
  - `busy` = 1 and `Time_Left` = N are visible from cycle e0+1.
  - `Time_Left` decrements at edges e0 + k×`TICK_DIV`.
- `expired` is registered and high for exactly the one cycle following edge e0 + N×`TICK_DIV`. `busy` falls on that same edge.
- The FSM may assert `start_timer` during the `expired` cycle; zero-gap back-to-back intervals are supported.
- Reset values: `expired` = 0, `busy` = 0, `Time_Left` = 0, `one_hz` = 0, divider counters = 0, parameters = defaults.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Shared package `tlc_pkg` holds:
  - interval codes: `INT_BASE`, `INT_EXT`, `INT_YEL`, `INT_BASE2`;
  - parameter select codes: `SEL_BASE`, `SEL_EXT`, `SEL_YEL`, `SEL_DEFAULTS`;
  - defaults: `T_BASE_DEF` = 6, `T_EXT_DEF` = 3, `T_YEL_DEF` = 2.
- The FSM lamp encodings also move to `tlc_pkg`.
- Sub-module `tick_divider`, parameterized by `TICK_DIV`, with a synchronous clear input.
  - Instantiated twice: once for the countdown phase (cleared on start), once free-running for `one_hz`.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Reset, then `start_timer` with `interval` = 0 → `Time_Left` sequence 6,5,…,1. `expired` pulses once, 24 cycles after the start edge; `busy` then 0.
- Program tEXT = 9 via `Prog_Sync`, then `interval` = 1 → 36-cycle countdown. Next, program `Time_Value` = 0 → stored as 1, giving a 4-cycle countdown.
- `interval` = 3 after setting tBASE = 15 → `Time_Left` starts at 30, `expired` after 120 cycles. `interval` = 5 → `expired` after 4 cycles.
- Restart: `start_timer` with `interval` = 2 is issued 2 cycles before the final tick of a tBASE count → no `expired` from the first count, then `expired` 8 cycles later.
- `Prog_Sync` with sel 0 and value 4 mid-count → the running count is unchanged. The next `interval` = 0 run lasts 16 cycles. Then sel 3 → tBASE returns to 6.
- `Reset` asserted mid-count → `busy`, `Time_Left` and `expired` are 0 the next cycle. Parameters return to 6/3/2, checked by a following run.
